// File: rtl/ahb_lsu_master.sv
// Single-transfer AHB-Lite master for a load/store unit: accepts one request
// at a time, issues a SINGLE NONSEQ transfer and reports a registered completion.
module ahb_lsu_master #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [2:0]        size_i,
    input  logic [DWIDTH-1:0] wdata_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic [DWIDTH-1:0] rdata_o,
    output logic              err_o,
    output logic [AWIDTH-1:0] haddr_o,
    output logic [1:0]        htrans_o,
    output logic              hwrite_o,
    output logic [2:0]        hsize_o,
    output logic [2:0]        hburst_o,
    output logic [DWIDTH-1:0] hwdata_o,
    input  logic              hready_i,
    input  logic              hresp_i,
    input  logic [DWIDTH-1:0] hrdata_i,
    output logic [1:0]        state_o
);

    // Requester handshake: a request is taken exactly in the cycle req_i and
    // gnt_o are both high; gnt_o only rises in IDLE, and each grant yields one
    // rvalid_o pulse later (err_o/rdata_o qualify that pulse).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [2:0]          size_q, size_d;
    logic [DWIDTH-1:0]   hwdata_q, hwdata_d;
    logic [1:0]          htrans_q, htrans_d;
    logic                rvalid_q, rvalid_d;
    logic                err_q, err_d;
    logic [DWIDTH-1:0]   rdata_q, rdata_d;
    logic                misaligned;

    function automatic logic [DWIDTH-1:0] lane_replicate(input logic [DWIDTH-1:0] d,
                                                         input logic [2:0]        sz);
        case (sz)
            3'd0:    return {4{d[7:0]}};
            3'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [DWIDTH-1:0] lane_extract(input logic [DWIDTH-1:0] d,
                                                       input logic [1:0]        off,
                                                       input logic [2:0]        sz);
        logic [DWIDTH-1:0] shifted;
        shifted = d >> {off, 3'b000};
        case (sz)
            3'd0:    return {24'b0, shifted[7:0]};
            3'd1:    return {16'b0, shifted[15:0]};
            default: return shifted;
        endcase
    endfunction

    assign misaligned = (size_i > 3'd2)
                     || ((size_i == 3'd1) && addr_i[0])
                     || ((size_i == 3'd2) && (addr_i[1:0] != 2'b00));

    // Reset also masks the grant so nothing is accepted while hresetn is low.
    assign gnt_o = req_i && hresetn && (state_q == IDLE);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        size_d   = size_q;
        hwdata_d = hwdata_q;
        htrans_d = htrans_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        rdata_d  = '0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    addr_d   = addr_i;
                    we_d     = we_i;
                    size_d   = size_i;
                    hwdata_d = lane_replicate(wdata_i, size_i);
                    if (misaligned) begin
                        state_d  = ERR;
                        htrans_d = HTRANS_IDLE;
                    end else begin
                        state_d  = ADDR;
                        htrans_d = HTRANS_NONSEQ;
                    end
                end
            end
            ADDR: begin
                if (hready_i) begin
                    state_d  = DATA;
                    htrans_d = HTRANS_IDLE;
                end
            end
            DATA: begin
                // A two-cycle ERROR response holds here on its first (hready low) cycle.
                if (hready_i) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b1;
                    if (hresp_i) begin
                        err_d = 1'b1;
                    end else if (!we_q) begin
                        rdata_d = lane_extract(hrdata_i, addr_q[1:0], size_q);
                    end
                end
            end
            ERR: begin
                state_d  = IDLE;
                rvalid_d = 1'b1;
                err_d    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            size_q   <= 3'd0;
            hwdata_q <= '0;
            htrans_q <= HTRANS_IDLE;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            size_q   <= size_d;
            hwdata_q <= hwdata_d;
            htrans_q <= htrans_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;
    assign haddr_o  = addr_q;
    assign htrans_o = htrans_q;
    assign hwrite_o = we_q;
    assign hsize_o  = size_q;
    assign hburst_o = 3'b000;
    assign hwdata_o = hwdata_q;
    assign state_o  = state_q;

endmodule
